ram_burst_ctrl: RTL

//  Upstream access sequencer for the single-port RAM (cs/mode/addr/data interface, mode=1 write, mode=0 read).

---
 rtl/ram_burst_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/ram_burst_ctrl.sv
// ---------------------------------------------------------------------------
// ram_burst_ctrl
//
// Upstream access sequencer for a single-port RAM (cs/mode/addr/data,
// mode=1 write, mode=0 read). Burst requests (start address + beats-1) are
// taken over a valid/ready handshake. A write burst streams beats from the
// wr_* handshake into the RAM. A read burst issues one read per clock and
// returns the data, in issue order, with a single-cycle rd_valid strobe.
// All RAM-side strobes are registered and owned by this block.
//
// Optional feature macro: RAM_INIT_EN
//   When defined, an INIT state follows reset release and writes INIT_VAL to
//   every RAM address 0..2**AW-1 (one per clock) before the block goes IDLE.
//
// Parameters
//   AW      RAM address width (address space 2**AW words)
//   DW      data width
//   LW      burst length field width (beats = req_len+1, 1..2**LW)
//   RD_LAT  RAM read latency in clocks (>=1)
//
// Ports
//   i_clk          clock, posedge
//   i_rst_n        asynchronous active-low reset
//   i_req_valid    burst request valid
//   o_req_ready    request accepted on i_req_valid && o_req_ready (IDLE only)
//   i_req_wr       1 = write burst, 0 = read burst
//   i_req_addr     burst start address
//   i_req_len      beats minus one
//   i_wr_valid     write beat valid
//   o_wr_ready     write beat accepted on i_wr_valid && o_wr_ready
//   i_wr_data      write beat data
//   o_rd_valid     read beat valid (single cycle, no backpressure)
//   o_rd_data      read beat data
//   o_busy         high whenever the FSM is not IDLE
//   o_cs           RAM chip select (registered)
//   o_mode         RAM mode, 1 = write, 0 = read (registered)
//   o_addr         RAM address (registered)
//   o_ram_wdata    RAM write data (registered)
//   i_ram_rdata    RAM read data
// ---------------------------------------------------------------------------
module ram_burst_ctrl #(
  parameter int AW     = 10,
  parameter int DW     = 8,
  parameter int LW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_wr,
  input  logic [AW-1:0] i_req_addr,
  input  logic [LW-1:0] i_req_len,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  input  logic [DW-1:0] i_wr_data,
  output logic          o_rd_valid,
  output logic [DW-1:0] o_rd_data,
  output logic          o_busy,
  output logic          o_cs,
  output logic          o_mode,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_ram_wdata,
  input  logic [DW-1:0] i_ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_INIT  = 3'd4
  } state_t;

`ifdef RAM_INIT_EN
  localparam logic [DW-1:0] INIT_VAL    = '0;
  localparam state_t        RESET_STATE = S_INIT;
`else
  localparam state_t        RESET_STATE = S_IDLE;
`endif

  state_t              r_state;
  logic [AW-1:0]       r_cur_addr;
  logic [LW-1:0]       r_beats_left;
  logic                r_cs;
  logic                r_mode;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_wdata;

  // One bit per clock of RAM read latency: marks which cycles will carry
  // valid ram_rdata belonging to one of our reads.
  logic [RD_LAT-1:0]   r_pend;
  logic                r_rd_valid;
  logic [DW-1:0]       r_rd_data;

  logic                w_issue_rd;
  logic                w_outstanding;
  logic                w_req_fire;
  logic                w_wr_fire;

  // A read is "issued" in the cycle in which cs=1/mode=0 is visible at the RAM.
  assign w_issue_rd    = r_cs & ~r_mode;
  // Reads still in flight: the one on the bus now plus those in the latency line.
  assign w_outstanding = w_issue_rd | (|r_pend);

  assign o_req_ready   = (r_state == S_IDLE);
  assign o_wr_ready    = (r_state == S_WRITE);
  assign o_busy        = (r_state != S_IDLE);
  assign w_req_fire    = i_req_valid & o_req_ready;
  assign w_wr_fire     = i_wr_valid & o_wr_ready;

  // Sequencer: every RAM strobe is a register written here. cs defaults low
  // so that any cycle without a beat is idle on the RAM; mode, addr and
  // wdata hold their last values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= RESET_STATE;
      r_cur_addr   <= '0;
      r_beats_left <= '0;
      r_cs         <= 1'b0;
      r_mode       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_cs <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_fire) begin
            r_cur_addr   <= i_req_addr;
            r_beats_left <= i_req_len;
            r_state      <= i_req_wr ? S_WRITE : S_READ;
          end
        end

        S_WRITE: begin
          // A beat accepted now appears on the RAM bus next cycle; a cycle
          // without wr_valid leaves counters alone and leaves cs low.
          if (w_wr_fire) begin
            r_cs       <= 1'b1;
            r_mode     <= 1'b1;
            r_addr     <= r_cur_addr;
            r_wdata    <= i_wr_data;
            r_cur_addr <= r_cur_addr + AW'(1);
            if (r_beats_left == '0) begin
              r_state <= S_IDLE;
            end else begin
              r_beats_left <= r_beats_left - LW'(1);
            end
          end
        end

        S_READ: begin
          r_cs       <= 1'b1;
          r_mode     <= 1'b0;
          r_addr     <= r_cur_addr;
          r_cur_addr <= r_cur_addr + AW'(1);
          if (r_beats_left == '0) begin
            r_state <= S_DRAIN;
          end else begin
            r_beats_left <= r_beats_left - LW'(1);
          end
        end

        S_DRAIN: begin
          // Leave once nothing is in flight, i.e. the final rd_valid is the
          // one being driven in this cycle.
          if (!w_outstanding) begin
            r_state <= S_IDLE;
          end
        end

`ifdef RAM_INIT_EN
        S_INIT: begin
          r_cs       <= 1'b1;
          r_mode     <= 1'b1;
          r_addr     <= r_cur_addr;
          r_wdata    <= INIT_VAL;
          r_cur_addr <= r_cur_addr + AW'(1);
          if (r_cur_addr == '1) begin
            r_state <= S_IDLE;
          end
        end
`endif

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read-return line: reset flushes it, so reads issued before a reset can
  // never produce an rd_valid afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend[0] <= w_issue_rd;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pend[i] <= r_pend[i-1];
      end
    end
  end

  // ram_rdata is sampled at the end of the cycle RD_LAT after the issue.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= r_pend[RD_LAT-1];
      if (r_pend[RD_LAT-1]) begin
        r_rd_data <= i_ram_rdata;
      end
    end
  end

  assign o_cs        = r_cs;
  assign o_mode      = r_mode;
  assign o_addr      = r_addr;
  assign o_ram_wdata = r_wdata;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;

endmodule
